// File: rtl/snoop_bus_arbiter.sv
// Round-robin snoop bus arbiter and BusRd/BusRdX transaction sequencer for six L1 caches.
// Optional `SNOOP_TIMEOUT_EN: bounds COLLECT to SNOOP_TIMEOUT cycles and pulses snoop_err on expiry.
module snoop_bus_arbiter #(
   parameter int NUM_REQ       = 6,
   parameter int ADDR_W        = 32,
   parameter int ID_W          = 3,
   parameter int SNOOP_TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_rdx,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      bus_valid,
   output logic                      bus_rd,
   output logic                      bus_rdx,
   output logic [ADDR_W-1:0]         bus_addr,
   output logic [ID_W-1:0]           bus_owner,
   input  logic [NUM_REQ-1:0]        snoop_ack,
   input  logic [NUM_REQ-1:0]        snoop_hit,
   input  logic [NUM_REQ-1:0]        snoop_hitm,
   output logic                      mem_req,
   output logic                      mem_we,
   input  logic                      mem_ack,
   output logic [NUM_REQ-1:0]        done,
   output logic                      shared,
   output logic                      snoop_err
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_BCAST   = 3'd1;
   localparam logic [2:0] S_COLLECT = 3'd2;
   localparam logic [2:0] S_FLUSH   = 3'd3;
   localparam logic [2:0] S_MEMRD   = 3'd4;
   localparam logic [2:0] S_RESP    = 3'd5;

   if (ID_W < $clog2(NUM_REQ)) begin : g_bad_id_w
      $error("ID_W too narrow for NUM_REQ");
   end
   if (SNOOP_TIMEOUT < 1) begin : g_bad_timeout
      $error("SNOOP_TIMEOUT must be positive");
   end

   function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   logic [2:0]         state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic               rdx_q, rdx_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [NUM_REQ-1:0] hit_q, hit_d;
   logic [NUM_REQ-1:0] hitm_q, hitm_d;

   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               bus_valid_q, bus_valid_d;
   logic               bus_rd_q, bus_rd_d;
   logic               bus_rdx_q, bus_rdx_d;
   logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
   logic [ID_W-1:0]    bus_owner_q, bus_owner_d;
   logic               mem_req_q, mem_req_d;
   logic               mem_we_q, mem_we_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               shared_q, shared_d;
   logic               snoop_err_q, snoop_err_d;

`ifdef SNOOP_TIMEOUT_EN
   localparam int TMO_W = $clog2(SNOOP_TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   logic [ID_W-1:0]    sel_idx;
   logic [NUM_REQ-1:0] owner_mask;
   logic [NUM_REQ-1:0] ack_in;
   logic [NUM_REQ-1:0] ack_all;

   // Round-robin pick: first set req bit strictly after the pointer, wrapping.
   always_comb begin
      int  idx;
      logic found;
      sel_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(ptr_q) + i) % NUM_REQ;
         if (!found && req[idx]) begin
            found   = 1'b1;
            sel_idx = ID_W'(idx);
         end
      end
   end

   assign owner_mask = onehot(bus_owner_q);
   assign ack_in     = snoop_ack & ~owner_mask;
   assign ack_all    = ack_q | ack_in;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      rdx_d       = rdx_q;
      ack_d       = ack_q;
      hit_d       = hit_q;
      hitm_d      = hitm_q;
      bus_addr_d  = bus_addr_q;
      bus_owner_d = bus_owner_q;
      snoop_err_d = 1'b0;
`ifdef SNOOP_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d     = S_BCAST;
               bus_owner_d = sel_idx;
               ptr_d       = sel_idx;
               rdx_d       = req_rdx[sel_idx];
               bus_addr_d  = req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
            end
         end
         S_BCAST: begin
            ack_d   = ack_all;
            hit_d   = hit_q | (ack_in & snoop_hit);
            hitm_d  = hitm_q | (ack_in & snoop_hitm);
            state_d = S_COLLECT;
`ifdef SNOOP_TIMEOUT_EN
            tmo_d   = '0;
`endif
         end
         S_COLLECT: begin
            ack_d  = ack_all;
            hit_d  = hit_q | (ack_in & snoop_hit);
            hitm_d = hitm_q | (ack_in & snoop_hitm);
            if (ack_all == ~owner_mask) begin
               state_d = (|hitm_d) ? S_FLUSH : S_MEMRD;
            end
`ifdef SNOOP_TIMEOUT_EN
            // Silent caches are simply left out of hit/hitm, i.e. treated as misses.
            else if (tmo_q == TMO_W'(SNOOP_TIMEOUT - 1)) begin
               snoop_err_d = 1'b1;
               state_d     = (|hitm_d) ? S_FLUSH : S_MEMRD;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         S_FLUSH: begin
            if (mem_ack) state_d = S_MEMRD;
         end
         S_MEMRD: begin
            if (mem_ack) state_d = S_RESP;
         end
         S_RESP: begin
            ack_d   = '0;
            hit_d   = '0;
            hitm_d  = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Moore outputs decoded from the next state so they line up with state_q.
   always_comb begin
      gnt_d       = (state_d != S_IDLE) ? onehot(bus_owner_d) : '0;
      bus_valid_d = (state_d == S_BCAST);
      bus_rd_d    = (state_d == S_BCAST) && !rdx_d;
      bus_rdx_d   = (state_d == S_BCAST) && rdx_d;
      mem_req_d   = (state_d == S_FLUSH) || (state_d == S_MEMRD);
      mem_we_d    = (state_d == S_FLUSH);
      done_d      = (state_d == S_RESP) ? onehot(bus_owner_d) : '0;
      shared_d    = (state_d == S_RESP) && (|hit_d) && !rdx_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= ID_W'(NUM_REQ - 1);
         rdx_q       <= 1'b0;
         ack_q       <= '0;
         hit_q       <= '0;
         hitm_q      <= '0;
         gnt_q       <= '0;
         bus_valid_q <= 1'b0;
         bus_rd_q    <= 1'b0;
         bus_rdx_q   <= 1'b0;
         bus_addr_q  <= '0;
         bus_owner_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         done_q      <= '0;
         shared_q    <= 1'b0;
         snoop_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         rdx_q       <= rdx_d;
         ack_q       <= ack_d;
         hit_q       <= hit_d;
         hitm_q      <= hitm_d;
         gnt_q       <= gnt_d;
         bus_valid_q <= bus_valid_d;
         bus_rd_q    <= bus_rd_d;
         bus_rdx_q   <= bus_rdx_d;
         bus_addr_q  <= bus_addr_d;
         bus_owner_q <= bus_owner_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         done_q      <= done_d;
         shared_q    <= shared_d;
         snoop_err_q <= snoop_err_d;
      end
   end

`ifdef SNOOP_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tmo_q <= '0;
      else      tmo_q <= tmo_d;
   end
`endif

   assign gnt       = gnt_q;
   assign bus_valid = bus_valid_q;
   assign bus_rd    = bus_rd_q;
   assign bus_rdx   = bus_rdx_q;
   assign bus_addr  = bus_addr_q;
   assign bus_owner = bus_owner_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign done      = done_q;
   assign shared    = shared_q;
   assign snoop_err = snoop_err_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench for snoop_bus_arbiter: stimulus queues expected grants/completions, a monitor checks them.
module tb_snoop_bus_arbiter;
   localparam int N  = 6;
   localparam int AW = 32;
   localparam int IW = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req = '0, req_rdx = '0;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    gnt;
   logic            bus_valid, bus_rd, bus_rdx;
   logic [AW-1:0]   bus_addr;
   logic [IW-1:0]   bus_owner;
   logic [N-1:0]    snoop_ack = '0, snoop_hit = '0, snoop_hitm = '0;
   logic            mem_req, mem_we;
   logic            mem_ack = 1'b0;
   logic [N-1:0]    done;
   logic            shared, snoop_err;

   always #5 clk = ~clk;

   snoop_bus_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .req_rdx(req_rdx), .req_addr(req_addr),
      .gnt(gnt), .bus_valid(bus_valid), .bus_rd(bus_rd), .bus_rdx(bus_rdx),
      .bus_addr(bus_addr), .bus_owner(bus_owner), .snoop_ack(snoop_ack),
      .snoop_hit(snoop_hit), .snoop_hitm(snoop_hitm), .mem_req(mem_req),
      .mem_we(mem_we), .mem_ack(mem_ack), .done(done), .shared(shared),
      .snoop_err(snoop_err)
   );

   typedef struct packed {
      logic [N-1:0]  gnt;
      logic          rd;
      logic          rdx;
      logic [AW-1:0] addr;
      logic [IW-1:0] owner;
   } gexp_t;

   typedef struct packed {
      logic [N-1:0] done;
      logic         shared;
      logic         flush;
      logic         err;
   } cexp_t;

   gexp_t gq[$];
   cexp_t cq[$];
   gexp_t ge;
   cexp_t ce;
   int    vectors = 0;
   int    miscompares = 0;
   logic  flush_seen = 1'b0, err_seen = 1'b0;
   logic [N-1:0] cfg_ack = '0, cfg_hit = '0, cfg_hitm = '0;
   logic [AW-1:0] addr_tab [N] = '{32'h0000_1A40, 32'h0000_2B80, 32'h0000_3CC0,
                                  32'h0000_4D00, 32'h0000_5E40, 32'h0000_6F80};

   initial for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_tab[i];

   // Snoopers answer one cycle after the broadcast; memory acks one cycle after mem_req.
   always @(negedge clk) begin
      if (bus_valid) begin
         snoop_ack  = cfg_ack;
         snoop_hit  = cfg_hit;
         snoop_hitm = cfg_hitm;
      end else begin
         snoop_ack  = '0;
         snoop_hit  = '0;
         snoop_hitm = '0;
      end
      mem_ack = rst && mem_req && !mem_ack;
   end

   always @(negedge clk) begin
      if (!rst) begin
         flush_seen = 1'b0;
         err_seen   = 1'b0;
      end else begin
         if (mem_req && mem_we) flush_seen = 1'b1;
         if (snoop_err) err_seen = 1'b1;
         if (bus_valid) begin
            vectors++;
            if (gq.size() == 0) begin
               miscompares++;
               $display("FAIL grant_unexpected gnt=%b owner=%0d", gnt, bus_owner);
            end else begin
               ge = gq.pop_front();
               if ({gnt, bus_rd, bus_rdx, bus_addr, bus_owner} !== ge) begin
                  miscompares++;
                  $display("FAIL grant got gnt=%b rd=%b rdx=%b addr=%h owner=%0d want gnt=%b rd=%b rdx=%b addr=%h owner=%0d",
                           gnt, bus_rd, bus_rdx, bus_addr, bus_owner, ge.gnt, ge.rd, ge.rdx, ge.addr, ge.owner);
               end
            end
         end
         if (|done) begin
            vectors++;
            if (cq.size() == 0) begin
               miscompares++;
               $display("FAIL done_unexpected done=%b", done);
            end else begin
               ce = cq.pop_front();
               if ({done, shared, flush_seen, err_seen, gnt} !== {ce, ce.done}) begin
                  miscompares++;
                  $display("FAIL done got done=%b shared=%b flush=%b err=%b gnt=%b want done=%b shared=%b flush=%b err=%b gnt=%b",
                           done, shared, flush_seen, err_seen, gnt, ce.done, ce.shared, ce.flush, ce.err, ce.done);
               end
            end
            flush_seen = 1'b0;
            err_seen   = 1'b0;
         end
      end
   end

   task automatic check_outputs_zero(input string name);
      vectors++;
      if ({gnt, bus_valid, bus_rd, bus_rdx, bus_addr, bus_owner, mem_req, mem_we, done, shared, snoop_err} !== '0) begin
         miscompares++;
         $display("FAIL %s outputs not zero: gnt=%b bv=%b mreq=%b mwe=%b done=%b addr=%h", name, gnt, bus_valid, mem_req, mem_we, done, bus_addr);
      end
   endtask

   task automatic expect_grant(input logic [IW-1:0] own, input logic rdx);
      logic [N-1:0] oh;
      oh = '0;
      oh[own] = 1'b1;
      gq.push_back('{gnt: oh, rd: !rdx, rdx: rdx, addr: addr_tab[own], owner: own});
   endtask

   task automatic expect_done(input logic [IW-1:0] own, input logic sh, input logic fl, input logic er);
      logic [N-1:0] oh;
      oh = '0;
      oh[own] = 1'b1;
      cq.push_back('{done: oh, shared: sh, flush: fl, err: er});
   endtask

   task automatic wait_bus_valid(input string name);
      int n = 0;
      do begin @(negedge clk); n++; end while (!bus_valid && n < 20);
      if (!bus_valid) begin
         vectors++; miscompares++;
         $display("FAIL %s no bus_valid within 20 cycles", name);
      end
   endtask

   task automatic wait_done(input string name, input int limit);
      int n = 0;
      do begin @(negedge clk); n++; end while (!(|done) && n < limit);
      if (!(|done)) begin
         vectors++; miscompares++;
         $display("FAIL %s no done within %0d cycles", name, limit);
      end
   endtask

   task automatic run_txn(input string name, input logic [N-1:0] r, input logic [N-1:0] rdxv,
                          input logic [N-1:0] ack, input logic [N-1:0] hit, input logic [N-1:0] hitm,
                          input logic [IW-1:0] own, input logic sh, input logic fl, input logic er,
                          input bit drop_early);
      cfg_ack = ack; cfg_hit = hit; cfg_hitm = hitm;
      req_rdx = rdxv;
      expect_grant(own, rdxv[own]);
      expect_done(own, sh, fl, er);
      req = r;
      wait_bus_valid(name);
      if (drop_early) req = '0;
      wait_done(name, 80);
      req = '0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      // Own-bit hit must be ignored; requester drops req early.
      run_txn("t1_rd_miss", 6'b000001, 6'b000000, 6'b111111, 6'b000001, 6'b000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_txn("t2_rd_shared", 6'b000100, 6'b000000, 6'b111111, 6'b000001, 6'b000000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      run_txn("t3_rdx_hitm", 6'b001000, 6'b001000, 6'b111111, 6'b010000, 6'b010000, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);

      // Reset while FLUSH is pending: everything clears and no done follows.
      cfg_ack = 6'b111111; cfg_hit = 6'b000001; cfg_hitm = 6'b000001;
      req_rdx = '0;
      expect_grant(3'd1, 1'b0);
      req = 6'b000010;
      n = 0;
      do begin @(negedge clk); n++; end while (!(mem_req && mem_we) && n < 20);
      vectors++;
      if (!(mem_req && mem_we)) begin
         miscompares++;
         $display("FAIL t5_flush_reach mem_req=%b mem_we=%b want 1 1", mem_req, mem_we);
      end
      rst = 1'b0;
      req = '0;
      #1;
      check_outputs_zero("t5_async_reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // All caches request: pointer restarts so grants run 0..5 then wrap to 0.
      cfg_ack = 6'b111111; cfg_hit = '0; cfg_hitm = '0;
      req_rdx = '0;
      for (int i = 0; i < 7; i++) begin
         expect_grant(IW'(i % N), 1'b0);
         expect_done(IW'(i % N), 1'b0, 1'b0, 1'b0);
      end
      req = 6'b111111;
      for (int i = 0; i < 7; i++) wait_done("t4_rr", 40);
      req = '0;
      repeat (4) @(negedge clk);

`ifdef SNOOP_TIMEOUT_EN
      run_txn("t6_timeout", 6'b000100, 6'b000000, 6'b011111, 6'b000000, 6'b000000, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

      repeat (4) @(negedge clk);
      vectors++;
      if (gq.size() != 0 || cq.size() != 0) begin
         miscompares++;
         $display("FAIL leftover_expectations grants=%0d dones=%0d want 0 0", gq.size(), cq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
